// File: rtl/matrix_bus_sniffer.sv
// matrix_bus_sniffer
// Passive receiver for the bicolor 8x8 LED matrix serial bus. It oversamples
// the bus in the clk domain and deserialises 8-bit row words, first bit in
// bit 7. Each word is tagged with a colour (from the column enables) and a row
// (from an internal row pointer) and stored in a 2x8x8 frame mirror. Malformed
// words are counted.
//
// Ports
//   clk, rst_n                  system clock, async active-low reset
//   ser_data, ser_clk           serial data and shift clock (async to clk)
//   ser_latch                   storage latch strobe (async to clk)
//   col_red_n, col_green_n      active-low column enables (async to clk)
//   word_valid                  1-cycle pulse per accepted word
//   word_data/word_row/word_color  last accepted word, held until next accept
//   frame_done                  pulses with word_valid on a row-7 green word
//   rd_color, rd_row, rd_data   mirror read port, 1-cycle latency, write-through
//   err_count                   saturating count of rejected words
//
// State     | meaning
// ST_IDLE   | no word in progress, bit count is 0
// ST_SHIFT  | bits are being accumulated, waiting for the latch strobe
module matrix_bus_sniffer #(
  parameter int IDLE_TIMEOUT = 4096,
  parameter int ERR_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_data,
  input  logic             ser_clk,
  input  logic             ser_latch,
  input  logic             col_red_n,
  input  logic             col_green_n,
  output logic             word_valid,
  output logic [7:0]       word_data,
  output logic [2:0]       word_row,
  output logic             word_color,
  output logic             frame_done,
  input  logic             rd_color,
  input  logic [2:0]       rd_row,
  output logic [7:0]       rd_data,
  output logic [ERR_W-1:0] err_count
);

  localparam int TMR_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(IDLE_TIMEOUT - 1);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t           state_q, state_d;
  logic [1:0]       data_sync, red_sync, green_sync;
  logic [2:0]       sclk_sync, latch_sync;
  logic [7:0]       shift_q, shift_nx;
  logic [3:0]       cnt_q, cnt_nx;
  logic [2:0]       row_q;
  logic [TMR_W-1:0] timer_q;
  logic [7:0]       mirror [16];

  logic clk_edge, latch_edge, red_s, green_s;
  logic accept, reject, timer_tc, timeout, err_inc;
  logic [3:0] wr_addr, rd_addr;

  assign clk_edge   = sclk_sync[1] & ~sclk_sync[2];
  assign latch_edge = latch_sync[1] & ~latch_sync[2];
  assign red_s      = red_sync[1];
  assign green_s    = green_sync[1];
  // Colour bit is 1 for green, i.e. when the red enable is inactive (high).
  assign wr_addr    = {red_s, row_q};
  assign rd_addr    = {rd_color, rd_row};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_sync  <= '0;
      red_sync   <= '0;
      green_sync <= '0;
      sclk_sync  <= '0;
      latch_sync <= '0;
    end else begin
      data_sync  <= {data_sync[0], ser_data};
      red_sync   <= {red_sync[0], col_red_n};
      green_sync <= {green_sync[0], col_green_n};
      sclk_sync  <= {sclk_sync[1:0], ser_clk};
      latch_sync <= {latch_sync[1:0], ser_latch};
    end
  end

  // The latch judges the post-shift register so a shift edge landing in the
  // same cycle as the latch edge still contributes its bit.
  always_comb begin
    state_d  = state_q;
    shift_nx = clk_edge ? {shift_q[6:0], data_sync[1]} : shift_q;
    cnt_nx   = cnt_q;
    if (clk_edge && cnt_q != 4'd15) cnt_nx = cnt_q + 4'd1;
    accept   = latch_edge && (cnt_nx == 4'd8) && (red_s ^ green_s);
    reject   = latch_edge && !accept;
    timer_tc = (timer_q == TMR_LAST);
    timeout  = timer_tc && !clk_edge && !latch_edge;
    err_inc  = reject || (timeout && cnt_q != 4'd0);
    case (state_q)
      ST_IDLE: begin
        if (latch_edge)    state_d = ST_IDLE;
        else if (clk_edge) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (latch_edge || timeout) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      row_q      <= '0;
      timer_q    <= '0;
      err_count  <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
      word_row   <= '0;
      word_color <= 1'b0;
      frame_done <= 1'b0;
      rd_data    <= '0;
      for (int i = 0; i < 16; i++) mirror[i] <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_nx;

      if (latch_edge || timeout) cnt_q <= '0;
      else                       cnt_q <= cnt_nx;

      if (clk_edge || timer_tc) timer_q <= '0;
      else                      timer_q <= timer_q + TMR_W'(1);

      if (timeout)              row_q <= '0;
      else if (accept && red_s) row_q <= row_q + 3'd1;

      if (err_inc && err_count != '1) err_count <= err_count + ERR_W'(1);

      word_valid <= accept;
      frame_done <= accept && red_s && (row_q == 3'd7);
      if (accept) begin
        word_data       <= shift_nx;
        word_row        <= row_q;
        word_color      <= red_s;
        mirror[wr_addr] <= shift_nx;
      end

      if (accept && wr_addr == rd_addr) rd_data <= shift_nx;
      else                              rd_data <= mirror[rd_addr];
    end
  end

endmodule

// File: tb/tb_matrix_bus_sniffer.sv
module tb_matrix_bus_sniffer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ser_data = 1'b0;
  logic       ser_clk = 1'b0;
  logic       ser_latch = 1'b0;
  logic       col_red_n = 1'b1;
  logic       col_green_n = 1'b1;
  logic       rd_color = 1'b0;
  logic [2:0] rd_row = 3'd0;
  logic       word_valid;
  logic [7:0] word_data;
  logic [2:0] word_row;
  logic       word_color;
  logic       frame_done;
  logic [7:0] rd_data;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  matrix_bus_sniffer #(.IDLE_TIMEOUT(4096), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ser_data(ser_data), .ser_clk(ser_clk),
    .ser_latch(ser_latch), .col_red_n(col_red_n), .col_green_n(col_green_n),
    .word_valid(word_valid), .word_data(word_data), .word_row(word_row),
    .word_color(word_color), .frame_done(frame_done), .rd_color(rd_color),
    .rd_row(rd_row), .rd_data(rd_data), .err_count(err_count)
  );

  int n_checks = 0;
  int n_pass = 0;

  // observed words: {frame_done, color, row, data}
  logic [12:0] obs_q[$];
  logic [12:0] exp_q[$];
  logic [7:0]  rd_at_valid[$];
  int          fd_cnt = 0;

  always @(negedge clk) begin
    if (rst_n && word_valid) begin
      obs_q.push_back({frame_done, word_color, word_row, word_data});
      rd_at_valid.push_back(rd_data);
    end
    if (rst_n && frame_done) fd_cnt++;
  end

  // reference model: mirror indexed color*8+row, plain integer row/err
  logic [7:0] m_mirror[16];
  int         m_row;
  int         m_err;
  logic       m_bits[$];

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_mirror[i] = 8'h00;
    m_row = 0;
    m_err = 0;
    m_bits.delete();
  endfunction

  function automatic void model_latch(logic rn, logic gn);
    int v;
    logic green, fd;
    if (m_bits.size() == 8 && rn != gn) begin
      v = 0;
      foreach (m_bits[i]) v = v * 2 + int'(m_bits[i]);
      green = (gn == 1'b0);
      fd = green && (m_row == 7);
      exp_q.push_back({fd, green, 3'(m_row), 8'(v)});
      m_mirror[(green ? 8 : 0) + m_row] = 8'(v);
      if (green) m_row = (m_row + 1) % 8;
    end else if (m_err < 255) begin
      m_err++;
    end
    m_bits.delete();
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_bit(logic b);
    ser_data = b;
    tick(2);
    ser_clk = 1'b1;
    tick(3);
    ser_clk = 1'b0;
    tick(2);
    m_bits.push_back(b);
  endtask

  task automatic bus_latch(logic rn, logic gn);
    col_red_n = rn;
    col_green_n = gn;
    tick(2);
    ser_latch = 1'b1;
    tick(3);
    ser_latch = 1'b0;
    tick(4);
    model_latch(rn, gn);
  endtask

  task automatic bus_word(logic [7:0] d, logic rn, logic gn);
    for (int i = 7; i >= 0; i--) bus_bit(d[i]);
    bus_latch(rn, gn);
  endtask

  task automatic read_entry(logic c, logic [2:0] r, output logic [7:0] d);
    rd_color = c;
    rd_row = r;
    tick(1);
    d = rd_data;
  endtask

  task automatic clear_queues();
    obs_q.delete();
    exp_q.delete();
    rd_at_valid.delete();
    fd_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    model_reset();
    tick(2);
    n_checks++;
    if ({word_valid, word_data, word_row, word_color, frame_done, rd_data} !== 21'd0)
      $display("FAIL reset_outputs got %h want 0",
               {word_valid, word_data, word_row, word_color, frame_done, rd_data});
    else n_pass++;
    n_checks++;
    if (err_count !== 8'h00) $display("FAIL reset_err got %h want 00", err_count);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [7:0] d;
    logic [7:0] seq;
    clear_queues();
    rd_color = 1'b0;
    rd_row = 3'd0;
    seq = 8'b1011_0001;
    for (int i = 7; i >= 0; i--) bus_bit(seq[i]);
    bus_latch(1'b0, 1'b1);
    n_checks++;
    if (obs_q.size() != 1) $display("FAIL basic_count got %0d want 1", obs_q.size());
    else n_pass++;
    if (obs_q.size() == 1) begin
      n_checks++;
      if (obs_q[0] !== 13'h00B1 || obs_q[0] !== exp_q[0])
        $display("FAIL basic_word got %h want %h", obs_q[0], 13'h00B1);
      else n_pass++;
      n_checks++;
      if (rd_at_valid[0] !== 8'hB1)
        $display("FAIL basic_rw_bypass got %h want b1", rd_at_valid[0]);
      else n_pass++;
    end
    read_entry(1'b0, 3'd0, d);
    n_checks++;
    if (d !== 8'hB1) $display("FAIL basic_read got %h want b1", d);
    else n_pass++;
  endtask

  task automatic test_frame();
    logic [7:0] d;
    clear_queues();
    for (int r = 0; r < 8; r++) begin
      bus_word(8'(r * 17), 1'b0, 1'b1);
      bus_word(8'(r * 17), 1'b1, 1'b0);
    end
    n_checks++;
    if (fd_cnt != 1) $display("FAIL frame_done_count got %0d want 1", fd_cnt);
    else n_pass++;
    n_checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL frame_count got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL frame_word%0d got %h want %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 8; r++) begin
        read_entry(c[0], 3'(r), d);
        n_checks++;
        if (d !== 8'(r * 17)) $display("FAIL frame_read c%0d r%0d got %h want %h", c, r, d, 8'(r * 17));
        else n_pass++;
      end
    clear_queues();
    bus_word(8'h5A, 1'b0, 1'b1);
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0] || obs_q[0][10:8] !== 3'd0)
      $display("FAIL frame_row_wrap got %0d words want row 0 word %h", obs_q.size(), exp_q[0]);
    else n_pass++;
  endtask

  task automatic test_bad_length();
    logic [7:0] d;
    clear_queues();
    for (int i = 0; i < 7; i++) bus_bit(1'($urandom_range(0, 1)));
    bus_latch(1'b0, 1'b1);
    for (int i = 0; i < 9; i++) bus_bit(1'($urandom_range(0, 1)));
    bus_latch(1'b0, 1'b1);
    n_checks++;
    if (obs_q.size() != 0) $display("FAIL badlen_words got %0d want 0", obs_q.size());
    else n_pass++;
    n_checks++;
    if (err_count !== 8'd2 || int'(err_count) != m_err)
      $display("FAIL badlen_err got %0d want 2", err_count);
    else n_pass++;
    read_entry(1'b0, 3'd0, d);
    n_checks++;
    if (d !== m_mirror[0]) $display("FAIL badlen_mirror got %h want %h", d, m_mirror[0]);
    else n_pass++;
  endtask

  task automatic test_col_lines();
    clear_queues();
    bus_word(8'($urandom), 1'b0, 1'b0);
    n_checks++;
    if (int'(err_count) != m_err || err_count !== 8'd3)
      $display("FAIL both_low_err got %0d want %0d", err_count, m_err);
    else n_pass++;
    bus_word(8'($urandom), 1'b1, 1'b1);
    n_checks++;
    if (int'(err_count) != m_err || obs_q.size() != 0)
      $display("FAIL both_high_err got %0d want %0d words %0d", err_count, m_err, obs_q.size());
    else n_pass++;
  endtask

  task automatic test_timeout();
    clear_queues();
    tick(4200);
    m_row = 0;
    n_checks++;
    if (int'(err_count) != m_err) $display("FAIL idle_timeout_err got %0d want %0d", err_count, m_err);
    else n_pass++;
    bus_word(8'($urandom), 1'b1, 1'b0);
    bus_word(8'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) bus_bit(1'($urandom_range(0, 1)));
    tick(4200);
    if (m_bits.size() != 0 && m_err < 255) m_err++;
    m_bits.delete();
    m_row = 0;
    n_checks++;
    if (int'(err_count) != m_err) $display("FAIL shift_timeout_err got %0d want %0d", err_count, m_err);
    else n_pass++;
    bus_word(8'($urandom), 1'b1, 1'b0);
    n_checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL timeout_count got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL timeout_word%0d got %h want %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    clear_queues();
    for (int i = 0; i < 300; i++) bus_latch(1'b0, 1'b1);
    n_checks++;
    if (err_count !== 8'hFF || m_err != 255) $display("FAIL err_saturate got %h want ff", err_count);
    else n_pass++;
    n_checks++;
    if (obs_q.size() != 0) $display("FAIL saturate_words got %0d want 0", obs_q.size());
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    logic [7:0] d;
    clear_queues();
    d = 8'($urandom);
    for (int i = 7; i >= 1; i--) bus_bit(d[i]);
    col_red_n = 1'b1;
    col_green_n = 1'b0;
    ser_data = d[0];
    tick(2);
    ser_clk = 1'b1;
    ser_latch = 1'b1;
    tick(3);
    ser_clk = 1'b0;
    ser_latch = 1'b0;
    tick(4);
    m_bits.push_back(d[0]);
    model_latch(1'b1, 1'b0);
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0] || obs_q[0][7:0] !== d)
      $display("FAIL same_cycle got %0d words want data %h", obs_q.size(), d);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] d;
    int nb, sel;
    logic rn, gn;
    clear_queues();
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 9);
      nb = (sel == 0) ? 7 : (sel == 1) ? 9 : 8;
      for (int i = 0; i < nb; i++) bus_bit(1'($urandom_range(0, 1)));
      sel = $urandom_range(0, 5);
      rn = (sel == 0) ? 1'b0 : (sel == 1) ? 1'b1 : (sel < 4) ? 1'b0 : 1'b1;
      gn = (sel == 0) ? 1'b0 : (sel == 1) ? 1'b1 : ~rn;
      bus_latch(rn, gn);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL rand_word%0d got %h want %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    for (int a = 0; a < 16; a++) begin
      read_entry(a[3], a[2:0], d);
      n_checks++;
      if (d !== m_mirror[a]) $display("FAIL rand_read%0d got %h want %h", a, d, m_mirror[a]);
      else n_pass++;
    end
    n_checks++;
    if (int'(err_count) != m_err) $display("FAIL rand_err got %0d want %0d", err_count, m_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] d;
    clear_queues();
    bus_word(8'h3C, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) bus_bit(1'($urandom_range(0, 1)));
    ser_clk = 1'b1;
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({word_valid, word_data, word_row, word_color, frame_done, rd_data, err_count} !== 29'd0)
      $display("FAIL async_reset got %h want 0",
               {word_valid, word_data, word_row, word_color, frame_done, rd_data, err_count});
    else n_pass++;
    ser_clk = 1'b0;
    tick(3);
    rst_n = 1'b1;
    model_reset();
    clear_queues();
    tick(2);
    d = 8'($urandom);
    bus_word(d, 1'b0, 1'b1);
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0])
      $display("FAIL fresh_word got %0d words want %h", obs_q.size(), exp_q[0]);
    else n_pass++;
    n_checks++;
    if (err_count !== 8'd0) $display("FAIL fresh_err got %0d want 0", err_count);
    else n_pass++;
    read_entry(1'b1, 3'd0, d);
    n_checks++;
    if (d !== m_mirror[8]) $display("FAIL fresh_mirror got %h want %h", d, m_mirror[8]);
    else n_pass++;
  endtask

  initial begin
    tick(1);
    test_reset();
    test_basic();
    test_frame();
    test_bad_length();
    test_col_lines();
    test_timeout();
    test_saturation();
    test_same_cycle();
    test_random();
    test_reset_mid_word();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
